// File: rtl/inv_box_pkg.sv
// Shared types and helpers for the invertible-box arbiter: FSM state,
// ID width sizing and the settle counter width.
package inv_box_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    function automatic int id_w(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/inv_box_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the winner is the first requester at or
// after ptr_i (modulo NREQ), found as the valid request with the smallest rank.
module rr_arbiter
    import inv_box_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [id_w(NREQ)-1:0]   ptr_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [id_w(NREQ)-1:0]   idx_o,
    output logic                    any_o
);

    localparam int IDW = id_w(NREQ);

    int best_rank_s;
    int rank_s;

    // rank each requester by its distance from the pointer and keep the nearest
    always_comb begin
        best_rank_s = NREQ;
        rank_s      = 0;
        idx_o       = '0;
        any_o       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rank_s = i - int'(ptr_i);
            if (rank_s < 0) begin
                rank_s = rank_s + NREQ;
            end else begin
                rank_s = rank_s;
            end
            if (req_i[i] && (rank_s < best_rank_s)) begin
                best_rank_s = rank_s;
                idx_o       = IDW'(i);
                any_o       = 1'b1;
            end else begin
                best_rank_s = best_rank_s;
            end
        end
        if (any_o) begin
            grant_o = NREQ'(1) << idx_o;
        end else begin
            grant_o = '0;
        end
    end

endmodule

// File: rtl/inv_box_arbiter.sv
// Shares one combinational invertible box between NREQ requesters: round-robin
// grant, registered data^mask drive, fixed settle wait, tagged Y response.
module inv_box_arbiter
    import inv_box_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    input  logic [NREQ*WIDTH-1:0]     req_inv,
    output logic [WIDTH-1:0]          box_in,
    input  logic                      box_y,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [id_w(NREQ)-1:0]     rsp_id,
    output logic                      rsp_y
);

    localparam int IDW = id_w(NREQ);

    state_e             state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     ptr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   box_in_q;
    logic               rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;
    logic               rsp_y_q;

    logic [NREQ-1:0]    grant_s;
    logic [IDW-1:0]     win_idx_s;
    logic               any_s;
    logic [WIDTH-1:0]   win_drive_s;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .idx_o   (win_idx_s),
        .any_o   (any_s)
    );

    // winner's drive value, next pointer and the IDLE-only accept strobe
    always_comb begin
        win_drive_s = req_data[win_idx_s*WIDTH +: WIDTH] ^ req_inv[win_idx_s*WIDTH +: WIDTH];
        if (int'(win_idx_s) == NREQ - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_idx_s + IDW'(1);
        end
        // rst gating keeps ready low while reset is held, not just after it
        if ((state_q == ST_IDLE) && !rst) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // transaction FSM: accept, settle countdown, hold response until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            box_in_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_s) begin
                        box_in_q <= win_drive_s;
                        rsp_id_q <= win_idx_s;
                        ptr_q    <= ptr_d;
                        cnt_q    <= CNT_W'(SETTLE - 1);
                        state_q  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rsp_y_q     <= box_y;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign box_in    = box_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_inv_box_arbiter.sv
// Directed bench: a SETTLE=1 instance driven from a vector table plus hand
// sequences, and a SETTLE=3 instance with a slow box model.
module tb_inv_box_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  req_valid, req_ready;
    logic [15:0] req_data, req_inv;
    logic [3:0]  box_in;
    logic        box_y, rsp_valid, rsp_ready, rsp_y;
    logic [1:0]  rsp_id;

    logic [3:0]  req_valid3, req_ready3;
    logic [15:0] req_data3, req_inv3;
    logic [3:0]  box_in3, d1_q, d2_q;
    logic        box_y3, rsp_valid3, rsp_ready3, rsp_y3;
    logic [1:0]  rsp_id3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inv_box_arbiter #(.NREQ(4), .WIDTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_inv(req_inv), .box_in(box_in), .box_y(box_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y)
    );

    inv_box_arbiter #(.NREQ(4), .WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_data(req_data3), .req_inv(req_inv3), .box_in(box_in3), .box_y(box_y3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_y(rsp_y3)
    );

    // instant parity box for the fast instance
    assign box_y = ^box_in;

    // slow box: Y follows box_in parity two cycles late
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_q <= 4'd0;
            d2_q <= 4'd0;
        end else begin
            d1_q <= box_in3;
            d2_q <= d1_q;
        end
    end
    assign box_y3 = ^d2_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] data;
        logic [15:0] inv;
        logic [1:0]  id;
        logic [3:0]  box;
        logic        y;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // round-robin over all four, data req3..req0 = 4,3,2,1
        vecs[0]  = '{4'b1111, 16'h4321, 16'h0000, 2'd0, 4'b0001, 1'b1};
        vecs[1]  = '{4'b1111, 16'h4321, 16'h0000, 2'd1, 4'b0010, 1'b1};
        vecs[2]  = '{4'b1111, 16'h4321, 16'h0000, 2'd2, 4'b0011, 1'b0};
        vecs[3]  = '{4'b1111, 16'h4321, 16'h0000, 2'd3, 4'b0100, 1'b1};
        vecs[4]  = '{4'b1111, 16'h4321, 16'h0000, 2'd0, 4'b0001, 1'b1};
        // inversion: 1010 ^ 0110 = 1100
        vecs[5]  = '{4'b0001, 16'h000A, 16'h0006, 2'd0, 4'b1100, 1'b0};
        // req1 alone moves ptr to 2: 1011 ^ 0101 = 1110
        vecs[6]  = '{4'b0010, 16'h00B0, 16'h0050, 2'd1, 4'b1110, 1'b1};
        // fairness skip from ptr=2 with only 0 and 1 valid
        vecs[7]  = '{4'b0011, 16'h00F7, 16'h0000, 2'd0, 4'b0111, 1'b1};
        vecs[8]  = '{4'b0011, 16'h00F7, 16'h0000, 2'd1, 4'b1111, 1'b0};
        // req3 full inversion: 1001 ^ 1111 = 0110, ptr wraps to 0
        vecs[9]  = '{4'b1000, 16'h9000, 16'hF000, 2'd3, 4'b0110, 1'b0};
        vecs[10] = '{4'b1100, 16'hA500, 16'h0F00, 2'd2, 4'b1010, 1'b0};
        vecs[11] = '{4'b1100, 16'hA500, 16'h0F00, 2'd3, 4'b1010, 1'b0};
        vecs[12] = '{4'b0101, 16'h0E0D, 16'h0000, 2'd0, 4'b1101, 1'b1};

        rst = 1'b1;
        req_valid = 4'b1111; req_data = 16'h4321; req_inv = 16'h0; rsp_ready = 1'b1;
        req_valid3 = 4'b0000; req_data3 = 16'h0; req_inv3 = 16'h0; rsp_ready3 = 1'b1;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_box_in", 32'(box_in), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);
        chk("reset_rsp_y", 32'(rsp_y), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b0000;

        // table: accept, sample one edge later, response taken the edge after
        for (int i = 0; i < 13; i++) begin
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            req_inv   = vecs[i].inv;
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(4'b0001 << vecs[i].id));
            @(posedge clk);
            @(negedge clk);
            req_valid = 4'b0000;
            chk($sformatf("v%0d_box_in", i), 32'(box_in), 32'(vecs[i].box));
            @(negedge clk);
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].id));
            chk($sformatf("v%0d_rsp_y", i), 32'(rsp_y), 32'(vecs[i].y));
            @(negedge clk);
            chk($sformatf("v%0d_rsp_done", i), 32'(rsp_valid), 32'h0);
        end

        // backpressure: ptr is 1 now; req1 wins, req0 keeps asking
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        req_data  = 16'h0057;
        req_inv   = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        chk("bp_box_in", 32'(box_in), 32'h5);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d_rsp_id", c), 32'(rsp_id), 32'h1);
            chk($sformatf("bp%0d_rsp_y", c), 32'(rsp_y), 32'h0);
            chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("bp_next_req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("bp_next_box_in", 32'(box_in), 32'h7);
        @(negedge clk);
        chk("bp_next_rsp_y", 32'(rsp_y), 32'h1);
        @(negedge clk);

        // SETTLE=3 with a box that settles two cycles after its input changes
        req_valid3 = 4'b0001;
        req_data3  = 16'h0004;
        req_inv3   = 16'h0005;
        #1;
        chk("s3_req_ready", 32'(req_ready3), 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid3 = 4'b0000;
        chk("s3_box_in", 32'(box_in3), 32'h1);
        chk("s3_valid_t0", 32'(rsp_valid3), 32'h0);
        @(negedge clk);
        chk("s3_valid_t1", 32'(rsp_valid3), 32'h0);
        @(negedge clk);
        chk("s3_valid_t2", 32'(rsp_valid3), 32'h0);
        @(negedge clk);
        chk("s3_valid_t3", 32'(rsp_valid3), 32'h1);
        chk("s3_rsp_y", 32'(rsp_y3), 32'h1);
        chk("s3_rsp_id", 32'(rsp_id3), 32'h0);
        @(negedge clk);
        chk("s3_done", 32'(rsp_valid3), 32'h0);

        // reset in the middle of SETTLE drops the transaction
        req_valid = 4'b0001;
        req_data  = 16'h000F;
        req_inv   = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("mid_box_in", 32'(box_in), 32'hF);
        rst = 1'b1;
        #1;
        chk("mid_rst_box_in", 32'(box_in), 32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_held_valid", 32'(rsp_valid), 32'h0);
        rst = 1'b0;
        req_valid = 4'b0100;
        req_data  = 16'h0100;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("post_rst_box_in", 32'(box_in), 32'h1);
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("post_rst_rsp_id", 32'(rsp_id), 32'h2);
        chk("post_rst_rsp_y", 32'(rsp_y), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inv_box_arbiter.md
# inv_box_arbiter

Shares one combinational invertible-pin primitive ("box", WIDTH data inputs, 1-bit output Y) between NREQ requesters. Each request carries input data plus a per-pin inversion mask. The block arbitrates round-robin, drives the box with data XOR mask, waits a fixed settle time, and returns the sampled Y tagged with the requester ID. It sits between requester logic and the box instance, so inversion is applied in one registered place instead of per-requester `$_NOT_` cells.

## Interface
Parameters:
- NREQ, 4: number of requesters; 2..8.
- WIDTH, 4: box data-input width; 1..16.
- SETTLE, 1: cycles box_in is held stable before Y is sampled; 1..15 (0 illegal).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_data  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- req_inv  in  NREQ*WIDTH  requester i inversion mask, same packing; 1 = invert pin.
- box_in  out  WIDTH  registered drive to box inputs.
- box_y  in  1  box output.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  max(1,clog2(NREQ))  index of served requester.
- rsp_y  out  1  sampled box_y.

## Operation
- States: IDLE, SETTLE, RESP.
- IDLE:
  - grant = round-robin pick among req_valid, starting at pointer ptr.
  - req_ready = onehot(grant) when any valid, else 0. It is combinational from req_valid and ptr, and 0 outside IDLE.
  - On handshake: box_in <= data ^ inv of winner; rsp_id <= winner; ptr <= winner+1 mod NREQ; cnt <= SETTLE-1; go SETTLE.
  - No valid: stay, ptr unchanged.
- SETTLE:
  - cnt != 0: cnt--.
  - cnt == 0: rsp_y <= box_y; rsp_valid <= 1; go RESP.
- RESP:
  - rsp_valid held with rsp_id/rsp_y stable until rsp_ready.
  - On rsp_ready: rsp_valid <= 0; go IDLE.
  - No new grant in the same cycle.
- box_in holds its last value outside SETTLE; it is never cleared except by reset.
- req_valid may drop without handshake; arbitration re-evaluates each IDLE cycle.
- ptr wraps NREQ-1 -> 0.
- The winner with ptr = p is the first i in p, p+1, ... (mod NREQ) with req_valid[i].
- rsp_ready high while rsp_valid low is ignored.

## Timing
- Reset values: state=IDLE, box_in=0, rsp_valid=0, rsp_id=0, rsp_y=0, ptr=0, cnt=0. req_ready=0 during reset.
- Accept edge t: box_in valid after t. Y is sampled at edge t+SETTLE. rsp_valid is high after t+SETTLE.
- Minimum transaction period is SETTLE+2 cycles with rsp_ready tied high. With SETTLE=1: accept t, sample t+1, rsp accepted t+2, next accept t+3.
- Reset asserted mid-transaction drops it silently. Outputs go to reset values immediately (async); first grant is possible on the first edge after deassertion.
- box_y must be stable SETTLE cycles after box_in changes; the block does not check this.

## Structure
- Package inv_box_pkg holds:
  - the state enum (IDLE, SETTLE, RESP);
  - an ID-width function max(1,clog2(n));
  - a localparam for the SETTLE counter width (4).
- Sub-module rr_arbiter (NREQ):
  - inputs: req vector and ptr;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- The top module holds the FSM, counter, and registers.

## Test plan
- Reset: rst pulse mid-SETTLE -> rsp_valid=0, box_in=0, state IDLE. The next request from requester 2 is granted and returns rsp_id=2.
- Inversion: requester 0, data=4'b1010, inv=4'b0110, box model Y=^box_in -> box_in=4'b1100, rsp_y=0, rsp_id=0, rsp_valid 1 cycle after accept (SETTLE=1).
- Round-robin: all four requesters valid continuously -> grant order 0,1,2,3,0. Each rsp_id matches the order and ptr wraps.
- Fairness skip: ptr=2, only req_valid[0] and [1] high -> grant 0, then 1. req_ready is never high for requesters 2 or 3.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid, rsp_id and rsp_y stay constant, req_ready stays 0. The next grant comes one cycle after rsp_ready.
- SETTLE=3: box model whose Y changes 2 cycles after box_in -> rsp_y reflects the settled value, with rsp_valid 3 cycles after accept.
